// File: rtl/gshare_predictor_if.sv
// Fetch-side prediction and EX-side resolution signals of the gshare predictor.
// The pipeline is the master; the predictor is the slave.
interface gshare_predictor_if #(
    parameter int INDEX_WIDTH = 6,
    parameter int HIST_WIDTH  = 6
);
    logic                   pred_valid;
    logic [31:0]            pc;
    logic                   stall;
    logic                   pred_taken;
    logic [INDEX_WIDTH-1:0] pred_index;
    logic [HIST_WIDTH-1:0]  pred_ghr;
    logic                   res_valid;
    logic [INDEX_WIDTH-1:0] res_index;
    logic [HIST_WIDTH-1:0]  res_ghr;
    logic                   res_taken;
    logic                   res_mispredict;

    modport master (
        output pred_valid, pc, stall,
        output res_valid, res_index, res_ghr, res_taken, res_mispredict,
        input  pred_taken, pred_index, pred_ghr
    );

    modport slave (
        input  pred_valid, pc, stall,
        input  res_valid, res_index, res_ghr, res_taken, res_mispredict,
        output pred_taken, pred_index, pred_ghr
    );
endinterface

// File: rtl/gshare_predictor.sv
// gshare predictor: PHT of saturating counters indexed by pc ^ speculative GHR,
// swept to weakly-not-taken after reset. Define GSHARE_STATS_EN for branch/mispredict counters.
module gshare_predictor #(
    parameter int INDEX_WIDTH = 6,
    parameter int HIST_WIDTH  = 6,
    parameter int CNT_WIDTH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    gshare_predictor_if.slave bp,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
);
    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam logic [CNT_WIDTH-1:0]   CNT_WNT  = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = '1;
    localparam logic [INDEX_WIDTH-1:0] PTR_LAST = INDEX_WIDTH'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state, state_next;
    logic [INDEX_WIDTH-1:0] init_ptr;
    logic [HIST_WIDTH-1:0]  spec_ghr;
    logic [CNT_WIDTH-1:0]   pht [DEPTH];

    logic [INDEX_WIDTH-1:0] index;
    logic [CNT_WIDTH-1:0]   res_cnt, res_cnt_next;
    logic                   pht_we;
    logic [INDEX_WIDTH-1:0] pht_waddr;
    logic [CNT_WIDTH-1:0]   pht_wdata;
    logic                   do_repair, do_shift;
    logic                   unused_pc_bits;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (init_ptr == PTR_LAST) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                init_ptr <= '0;
        else if (state == INIT) init_ptr <= init_ptr + 1'b1;
    end

    assign ready = (state == RUN);

    assign index         = bp.pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(spec_ghr);
    assign bp.pred_index = index;
    assign bp.pred_ghr   = spec_ghr;
    assign bp.pred_taken = ready & pht[index][CNT_WIDTH-1];

    assign unused_pc_bits = ^{bp.pc[31:INDEX_WIDTH+2], bp.pc[1:0]};

    always_comb begin
        res_cnt      = pht[bp.res_index];
        res_cnt_next = res_cnt;
        if (bp.res_taken && res_cnt != CNT_MAX)        res_cnt_next = res_cnt + 1'b1;
        else if (!bp.res_taken && res_cnt != '0)       res_cnt_next = res_cnt - 1'b1;
    end

    // The sweep owns the single write port during INIT; training owns it in RUN.
    assign pht_we    = !rst && (state == INIT || bp.res_valid);
    assign pht_waddr = (state == INIT) ? init_ptr : bp.res_index;
    assign pht_wdata = (state == INIT) ? CNT_WNT  : res_cnt_next;

    // NOTE: the PHT array has no reset branch; the INIT sweep clears it, which
    // keeps it mappable to plain RAM instead of DEPTH resettable flops.
    always_ff @(posedge clk) begin
        if (pht_we) pht[pht_waddr] <= pht_wdata;
    end

    assign do_repair = ready && bp.res_valid && bp.res_mispredict;
    assign do_shift  = ready && bp.pred_valid && !bp.stall;

    // Truncating {hist, bit} covers HIST_WIDTH == 1 without a separate slice.
    always_ff @(posedge clk) begin
        if (rst)            spec_ghr <= '0;
        else if (do_repair) spec_ghr <= HIST_WIDTH'({bp.res_ghr, bp.res_taken});
        else if (do_shift)  spec_ghr <= HIST_WIDTH'({spec_ghr, bp.pred_taken});
    end

`ifdef GSHARE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (ready && bp.res_valid) begin
            if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
            if (bp.res_mispredict && stat_mispredicts != '1)
                stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios plus randomized
// traffic, compared each cycle against a table-level reference model.
module tb_gshare_predictor;
    localparam int IW    = 6;
    localparam int HW    = 6;
    localparam int CW    = 2;
    localparam int DEPTH = 1 << IW;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int CWNT  = (1 << (CW - 1)) - 1;
    localparam int HMASK = (1 << HW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [31:0] stat_branches, stat_mispredicts;

    gshare_predictor_if #(.INDEX_WIDTH(IW), .HIST_WIDTH(HW)) bp ();

    gshare_predictor #(.INDEX_WIDTH(IW), .HIST_WIDTH(HW), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .ready            (ready),
        .bp               (bp),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    int m_pht [DEPTH];
    int m_ghr;
    int m_cycles;
    int m_branches;
    int m_mispredicts;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return m_cycles >= DEPTH;
    endfunction

    function automatic int m_index(input logic [31:0] p);
        return ((int'(p) >>> 2) & (DEPTH - 1)) ^ m_ghr;
    endfunction

    function automatic bit m_taken(input logic [31:0] p);
        return m_ready() && (m_pht[m_index(p)] > CWNT);
    endfunction

    task automatic m_reset();
        foreach (m_pht[i]) m_pht[i] = CWNT;
        m_ghr = 0; m_cycles = 0; m_branches = 0; m_mispredicts = 0;
    endtask

    // Drive one cycle, compare outputs against the model, then advance both.
    task automatic step(input bit r, input bit pv, input logic [31:0] p, input bit st,
                        input bit rv, input int ri, input int rg, input bit rt, input bit rm);
        bit pt;
        rst = r;
        bp.pred_valid = pv; bp.pc = p; bp.stall = st;
        bp.res_valid = rv; bp.res_index = IW'(ri); bp.res_ghr = HW'(rg);
        bp.res_taken = rt; bp.res_mispredict = rm;
        #1;
        pt = m_taken(p);
        check("ready", 64'(ready), 64'(m_ready()));
        check("pred_taken", 64'(bp.pred_taken), 64'(pt));
        check("pred_index", 64'(bp.pred_index), 64'(m_index(p)));
        check("pred_ghr", 64'(bp.pred_ghr), 64'(m_ghr));
`ifdef GSHARE_STATS_EN
        check("stat_branches", 64'(stat_branches), 64'(m_branches));
        check("stat_mispredicts", 64'(stat_mispredicts), 64'(m_mispredicts));
`else
        check("stat_branches_off", 64'(stat_branches), 64'd0);
        check("stat_mispredicts_off", 64'(stat_mispredicts), 64'd0);
`endif
        @(posedge clk);
        if (r) begin
            m_reset();
        end else if (!m_ready()) begin
            m_cycles++;
        end else begin
            if (rv) begin
                m_branches++;
                if (rm) m_mispredicts++;
                if (rt) m_pht[ri] = (m_pht[ri] < CMAX) ? m_pht[ri] + 1 : CMAX;
                else    m_pht[ri] = (m_pht[ri] > 0)    ? m_pht[ri] - 1 : 0;
            end
            if (rv && rm)         m_ghr = ((rg << 1) | int'(rt)) & HMASK;
            else if (pv && !st)   m_ghr = ((m_ghr << 1) | int'(pt)) & HMASK;
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] p);
        step(1'b0, 1'b0, p, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic train(input int ri, input bit rt, input bit rm);
        step(1'b0, 1'b0, 32'h100, 1'b0, 1'b1, ri, 0, rt, rm);
    endtask

    initial begin
        rst = 1'b1;
        bp.pred_valid = 1'b0; bp.pc = '0; bp.stall = 1'b0;
        bp.res_valid = 1'b0; bp.res_index = '0; bp.res_ghr = '0;
        bp.res_taken = 1'b0; bp.res_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();

        // Sweep: ready must stay low for DEPTH cycles, then rise.
        repeat (DEPTH) idle(32'h100);
        check("ready_after_sweep", 64'(ready), 64'd1);
        check("probe_taken", 64'(bp.pred_taken), 64'd0);
        check("probe_index", 64'(bp.pred_index), 64'h00);

        // Saturating training at index 0: 01 -> 10 -> 11 -> 11, then back down.
        train(0, 1'b1, 1'b0);
        check("train1_taken", 64'(bp.pred_taken), 64'd1);
        train(0, 1'b1, 1'b0);
        train(0, 1'b1, 1'b0);
        train(0, 1'b0, 1'b0);
        check("sat_hold_taken", 64'(bp.pred_taken), 64'd1);
        train(0, 1'b0, 1'b0);
        check("down_to_01", 64'(bp.pred_taken), 64'd0);

        // Speculative shift of not-taken predictions, then stalled fetch.
        repeat (3) step(1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        check("ghr_after_nt", 64'(bp.pred_ghr), 64'd0);
        repeat (2) step(1'b0, 1'b1, 32'h104, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        check("ghr_stalled", 64'(bp.pred_ghr), 64'd0);

        // Repair wins over a same-cycle speculative shift.
        step(1'b0, 1'b0, 32'h104, 1'b0, 1'b1, 10, 6'b010110, 1'b1, 1'b1);
        check("ghr_repair_a", 64'(bp.pred_ghr), 64'(6'b101101));
        step(1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 11, 6'b000011, 1'b1, 1'b1);
        check("ghr_repair_b", 64'(bp.pred_ghr), 64'(6'b000111));

        // Read/write collision at index 5 (pc[7:2]=2 ^ ghr=7).
        step(1'b0, 1'b0, 32'h08, 1'b0, 1'b1, 5, 0, 1'b1, 1'b0);
        check("collision_next", 64'(bp.pred_taken), 64'd1);

        // Resolution during INIT is dropped; counters restart after reset.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        check("ready_mid_reset", 64'(ready), 64'd0);
        repeat (DEPTH) step(1'b0, 1'b1, $urandom, 1'b0, 1'b1, $urandom_range(DEPTH - 1),
                            $urandom_range(HMASK), 1'b1, 1'b1);

        // Stats: 10 resolutions, 3 of them mispredicted.
        for (int i = 0; i < 10; i++) train(i, i[0], i < 3);
`ifdef GSHARE_STATS_EN
        check("stat_branches_10", 64'(stat_branches), 64'd10);
        check("stat_mispredicts_3", 64'(stat_mispredicts), 64'd3);
`endif
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        check("stat_branches_rst", 64'(stat_branches), 64'd0);
        check("stat_mispredicts_rst", 64'(stat_mispredicts), 64'd0);
        check("ready_rst", 64'(ready), 64'd0);

        // Randomized traffic with occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            bit rv;
            rv = ($urandom_range(9) < 4);
            step($urandom_range(499) == 0, $urandom_range(3) != 0, $urandom,
                 $urandom_range(4) == 0, rv, $urandom_range(DEPTH - 1),
                 $urandom_range(HMASK), 1'($urandom), rv && ($urandom_range(9) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
